// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready bitwise logic unit with registered flags
// and an accumulator that can stand in for operand A.
module logic_unit_pipe #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [2:0]       F,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] Out,
  output logic             Z,
  output logic             N,
  output logic             P
);
  logic             r_s1_valid, r_use_acc;
  logic [Width-1:0] r_a, r_b, r_acc;
  logic [2:0]       r_f;
  logic [Width-1:0] w_x, w_r;
  logic             w_s1_adv, w_in_fire;

  assign w_s1_adv  = r_s1_valid & (~out_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign w_in_fire = in_valid & in_ready;
  // acc is written on every advance, so it always holds the preceding op's result
  assign w_x       = r_use_acc ? r_acc : r_a;

  always_comb begin
    w_r = '0;
    case (r_f)
      3'b000: w_r = w_x & r_b;
      3'b001: w_r = w_x | r_b;
      3'b010: w_r = w_x ^ r_b;
      3'b011: w_r = ~w_x;
      3'b100: w_r = ~(w_x & r_b);
      3'b101: w_r = ~(w_x | r_b);
      3'b110: w_r = ~(w_x ^ r_b);
      3'b111: w_r = w_x & ~r_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_f        <= '0;
      r_use_acc  <= 1'b0;
    end else begin
      r_s1_valid <= w_in_fire | (r_s1_valid & ~w_s1_adv);
      if (w_in_fire) begin
        r_a       <= A;
        r_b       <= B;
        r_f       <= F;
        r_use_acc <= use_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Out       <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      P         <= 1'b0;
      r_acc     <= '0;
    end else if (w_s1_adv) begin
      out_valid <= 1'b1;
      Out       <= w_r;
      Z         <= ~|w_r;
      N         <= w_r[Width-1];
      P         <= ~^w_r;
      r_acc     <= w_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
